// File: rtl/updown_mod_counter.sv
// Up/down modulo counter (0..MAX_VAL) with parallel load, wrap or saturate boundaries and tc.
// Define UPDOWN_MOD_COUNTER_GRAY_EN to add a registered Gray-code copy of the count.
module updown_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             Y,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             tc,
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    output logic [WIDTH-1:0] gray,
`endif
    output logic             wrap
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_mod_counter: WIDTH must be in 2..32");
    end
    if (64'(MAX_VAL) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_max
        $error("updown_mod_counter: MAX_VAL does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MaxCount = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] One      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;

    assign at_max  = (count_q == MaxCount);
    assign at_zero = (count_q == '0);

    // Load is clamped so the count can never leave 0..MAX_VAL.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > MaxCount) ? MaxCount : load_val;
        end else if (en) begin
            if (!Y) begin
                if (!at_max) begin
                    count_d = count_q + One;
                end else if (!sat) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - One;
                end else if (!sat) begin
                    count_d = MaxCount;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_q;

    // Encoded from the next count so gray stays cycle-aligned with count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gray_q <= '0;
        end else begin
            gray_q <= count_d ^ (count_d >> 1);
        end
    end

    assign gray = gray_q;
`endif

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = (!Y && at_max) || (Y && at_zero);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: MAX_VAL=15 and MAX_VAL=9 instances driven from shared inputs.
module tb_updown_mod_counter;

    localparam int unsigned W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         en;
    logic         y;
    logic         load;
    logic         sat;
    logic [W-1:0] load_val;

    logic [W-1:0] count9, count15;
    logic         tc9, tc15, wrap9, wrap15;
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    logic [W-1:0] gray9, gray15;
`endif

    always #5 clock = ~clock;

    updown_mod_counter #(.WIDTH(W), .MAX_VAL(9)) dut9 (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .Y        (y),
        .load     (load),
        .load_val (load_val),
        .sat      (sat),
        .count    (count9),
        .tc       (tc9),
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
        .gray     (gray9),
`endif
        .wrap     (wrap9)
    );

    updown_mod_counter #(.WIDTH(W), .MAX_VAL(15)) dut15 (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .Y        (y),
        .load     (load),
        .load_val (load_val),
        .sat      (sat),
        .count    (count15),
        .tc       (tc15),
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
        .gray     (gray15),
`endif
        .wrap     (wrap15)
    );

    typedef struct packed {
        logic         ld;
        logic [W-1:0] lv;
        logic         en;
        logic         y;
        logic         sat;
        logic [W-1:0] c;
        logic         w;
        logic         t;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] c;
        logic         w;
        logic         t;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one vector on the MAX_VAL=9 instance; its expectation is scored after the edge.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        load     = v.ld;
        load_val = v.lv;
        en       = v.en;
        y        = v.y;
        sat      = v.sat;
        sb.push_back({v.c, v.w, v.t});
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got count %0d, expected an entry", name, count9);
        end else begin
            e = sb.pop_front();
            check({name, " count"}, 32'(count9), 32'(e.c));
            check({name, " wrap"}, 32'(wrap9), 32'(e.w));
            check({name, " tc"}, 32'(tc9), 32'(e.t));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    initial begin
        int exp9, exp15;
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
        logic [W-1:0] prev_gray, exp_gray;
`endif
        //          ld   lv     en    y     sat   c      w     t
        tbl[0]  = {1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
        tbl[1]  = {1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0};
        tbl[2]  = {1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
        tbl[3]  = {1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd9,  1'b1, 1'b0};
        tbl[4]  = {1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd8,  1'b0, 1'b0};
        tbl[5]  = {1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 4'd9,  1'b0, 1'b1};
        tbl[6]  = {1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0};
        tbl[7]  = {1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0};
        tbl[8]  = {1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0};
        tbl[9]  = {1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0};
        tbl[10] = {1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 4'd9,  1'b0, 1'b1};
        tbl[11] = {1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0};
        tbl[12] = {1'b1, 4'd15, 1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 1'b0};
        tbl[13] = {1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1};
        tbl[14] = {1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1};
        tbl[15] = {1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0};
        tbl[16] = {1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0};
        tbl[17] = {1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd2,  1'b0, 1'b0};

        reset    = 1'b1;
        en       = 1'b1;
        y        = 1'b1;
        load     = 1'b1;
        sat      = 1'b0;
        load_val = 4'd6;
        #2;
        check("reset count9", 32'(count9), 32'd0);
        check("reset wrap9", 32'(wrap9), 32'd0);
        check("reset tc9 down", 32'(tc9), 32'd1);
        check("reset count15", 32'(count15), 32'd0);
        check("reset tc15 down", 32'(tc15), 32'd1);
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
        check("reset gray15", 32'(gray15), 32'd0);
        prev_gray = '0;
`endif
        // Edge at t=5 falls inside reset with load/en active and must be ignored.
        #8;
        check("load under reset", 32'(count15), 32'd0);
        reset = 1'b0;
        load  = 1'b0;
        y     = 1'b0;
        #1;
        check("release tc15 up", 32'(tc15), 32'd0);

        for (int i = 1; i <= 17; i++) begin
            @(posedge clock);
            #1;
            exp15 = i % 16;
            exp9  = i % 10;
            check($sformatf("up15[%0d] count", i), 32'(count15), 32'(exp15));
            check($sformatf("up15[%0d] wrap", i), 32'(wrap15), 32'(i == 16));
            check($sformatf("up15[%0d] tc", i), 32'(tc15), 32'(exp15 == 15));
            check($sformatf("up9[%0d] count", i), 32'(count9), 32'(exp9));
            check($sformatf("up9[%0d] wrap", i), 32'(wrap9), 32'(i == 10));
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
            exp_gray = 4'(exp15 ^ (exp15 >> 1));
            check($sformatf("gray15[%0d]", i), 32'(gray15), 32'(exp_gray));
            check($sformatf("gray15[%0d] one-bit step", i), 32'($countones(gray15 ^ prev_gray)),
                  32'd1);
            prev_gray = gray15;
`endif
        end

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Saturating up count from 0: stops at 9 with no wrap.
        apply({1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}, "sat load0");
        for (int i = 1; i <= 12; i++) begin
            apply({1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'((i > 9) ? 9 : i), 1'b0, 1'b1 && (i >= 9)},
                  $sformatf("sat up[%0d]", i));
        end

        // Asynchronous reset mid-count, then resume from 0.
        apply({1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0}, "pre-reset load7");
        #3;
        reset = 1'b1;
        #1;
        check("async reset count", 32'(count9), 32'd0);
        check("async reset wrap", 32'(wrap9), 32'd0);
        load     = 1'b1;
        load_val = 4'd5;
        en       = 1'b1;
        @(posedge clock);
        #1;
        check("load ignored in reset", 32'(count9), 32'd0);
        #2;
        reset = 1'b0;
        apply({1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0}, "post-reset 1");
        apply({1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0}, "post-reset 2");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
